// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Holds the sequencer state encoding and the PC wrap helper.
package fetch_pkg;

  localparam int DEF_XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam int DEF_IMEM_BYTES = 84;
  localparam logic [DEF_XLEN-1:0] DEF_RESET_PC = '0;

  typedef enum logic [2:0] {
    FETCH_BOOT,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_HOLD,
    FETCH_DROP
  } fetch_state_e;

  function automatic logic [DEF_XLEN-1:0] pc_next_wrap(
    input logic [DEF_XLEN-1:0] pc,
    input logic [DEF_XLEN-1:0] limit
  );
    logic [DEF_XLEN-1:0] nxt;
    nxt = pc + DEF_XLEN'(INSTR_BYTES);
    return (nxt >= limit) ? '0 : nxt;
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready buffer between fetch and decode.
// Flush beats load, and load beats a plain transfer.
module fetch_out_reg
  import fetch_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_load_pc,
  input  logic [31:0]     i_load_instr,
  input  logic            i_flush,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_instr
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_load_pc;
      r_instr <= i_load_instr;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, issues one imem read at a time,
// buffers results for decode and handles redirects with response drop.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              XLEN       = DEF_XLEN,
  parameter int              IMEM_BYTES = DEF_IMEM_BYTES,
  parameter logic [XLEN-1:0] RESET_PC   = DEF_RESET_PC
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  output logic            o_fetch_valid,
  input  logic            i_fetch_ready,
  output logic [XLEN-1:0] o_fetch_pc,
  output logic [31:0]     o_fetch_instr,
  output logic            o_fetch_fault
);

  localparam logic [XLEN-1:0] LIMIT = XLEN'(IMEM_BYTES);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_req;
  logic [XLEN-1:0] r_addr;
  logic            r_fault;

  logic            w_valid;
  logic            w_redir;
  logic            w_illegal;
  logic [XLEN-1:0] w_target;
  logic            w_free;
  logic            w_got;
  logic            w_load;
  logic [XLEN-1:0] w_pc_next;

  assign w_redir   = i_redirect_valid && (r_state != FETCH_BOOT);
  assign w_illegal = (i_redirect_pc[1:0] != 2'b00) ||
                     (i_redirect_pc >= LIMIT);
  assign w_target  = w_illegal ? RESET_PC :
                     {i_redirect_pc[XLEN-1:2], 2'b00};
  assign w_free    = !w_valid || i_fetch_ready;
  assign w_got     = (r_state == FETCH_WAIT) && i_imem_rvalid;
  assign w_load    = w_got && w_free && !w_redir;
  assign w_pc_next = pc_next_wrap(r_pc, LIMIT);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= FETCH_BOOT;
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_fault <= 1'b0;
    end else begin
      r_req   <= 1'b0;
      r_fault <= 1'b0;
      if (w_redir) begin
        r_pc    <= w_target;
        r_fault <= w_illegal;
        if (r_state == FETCH_WAIT && !i_imem_rvalid) begin
          r_state <= FETCH_DROP;
        end else begin
          r_state <= FETCH_REQ;
          r_req   <= 1'b1;
          r_addr  <= w_target;
        end
      end else begin
        unique case (r_state)
          FETCH_BOOT: begin
            r_state <= FETCH_REQ;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
          FETCH_REQ: begin
            r_state <= FETCH_WAIT;
          end
          FETCH_WAIT: begin
            if (i_imem_rvalid) begin
              // a full, unconsumed buffer forces a refetch of this pc
              if (w_free) begin
                r_pc <= w_pc_next;
                if (i_fetch_ready) begin
                  r_state <= FETCH_REQ;
                  r_req   <= 1'b1;
                  r_addr  <= w_pc_next;
                end else begin
                  r_state <= FETCH_HOLD;
                end
              end else begin
                r_state <= FETCH_HOLD;
              end
            end
          end
          FETCH_HOLD: begin
            if (i_fetch_ready) begin
              r_state <= FETCH_REQ;
              r_req   <= 1'b1;
              r_addr  <= r_pc;
            end
          end
          FETCH_DROP: begin
            if (i_imem_rvalid) begin
              r_state <= FETCH_REQ;
              r_req   <= 1'b1;
              r_addr  <= r_pc;
            end
          end
          default: r_state <= FETCH_BOOT;
        endcase
      end
    end
  end

  fetch_out_reg #(
    .XLEN(XLEN)
  ) u_out (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load       (w_load),
    .i_load_pc    (r_pc),
    .i_load_instr (i_imem_rdata),
    .i_flush      (w_redir),
    .i_ready      (i_fetch_ready),
    .o_valid      (w_valid),
    .o_pc         (o_fetch_pc),
    .o_instr      (o_fetch_instr)
  );

  assign o_imem_req    = r_req;
  assign o_imem_addr   = r_addr;
  assign o_fetch_valid = w_valid;
  assign o_fetch_fault = r_fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a latency-programmable
// instruction memory model.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        fetch_fault;

  int          total;
  int          bad;
  int          m_lat;
  int          m_cnt;
  logic        m_pend;
  logic [31:0] m_addr;

  fetch_sequencer dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_imem_req       (imem_req),
    .o_imem_addr      (imem_addr),
    .i_imem_rvalid    (imem_rvalid),
    .i_imem_rdata     (imem_rdata),
    .o_fetch_valid    (fetch_valid),
    .i_fetch_ready    (fetch_ready),
    .o_fetch_pc       (fetch_pc),
    .o_fetch_instr    (fetch_instr),
    .o_fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hC0DE_0000 | a;
  endfunction

  // memory: captures a request, answers m_lat cycles later
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (m_pend) begin
      if (m_cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_at(m_addr);
        m_pend      = 1'b0;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
    if (imem_req) begin
      m_pend = 1'b1;
      m_cnt  = m_lat;
      m_addr = imem_addr;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fetch_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 ||
        fetch_valid !== 1'b0 || fetch_pc !== 32'h0 ||
        fetch_instr !== 32'h0 || fetch_fault !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals: req=%b addr=%h v=%b pc=%h in=%h f=%b want 0",
               imem_req, imem_addr, fetch_valid, fetch_pc,
               fetch_instr, fetch_fault);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_valid !== 1'b0) begin
      bad++;
      $display("FAIL first_req: req=%b addr=%h v=%b want 1/0/0",
               imem_req, imem_addr, fetch_valid);
    end
    @(negedge clk);
    total++;
    if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin
      bad++;
      $display("FAIL first_wait: req=%b v=%b want 0/0", imem_req, fetch_valid);
    end
    @(negedge clk);
    total++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0 ||
        fetch_instr !== word_at(32'h0)) begin
      bad++;
      $display("FAIL first_load: v=%b pc=%h in=%h want 1/0/%h",
               fetch_valid, fetch_pc, fetch_instr, word_at(32'h0));
    end
  endtask

  task automatic test_stream();
    int nreq;
    int nval;
    int exp_a;
    m_lat = 1;
    fetch_ready = 1'b1;
    do_reset();
    nreq = 0;
    nval = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        exp_a = (nreq * 4) % 84;
        total++;
        if (imem_addr !== 32'(exp_a)) begin
          bad++;
          $display("FAIL stream_addr[%0d]: got %h want %h",
                   nreq, imem_addr, 32'(exp_a));
        end
        nreq++;
      end
      if (fetch_valid === 1'b1) begin
        exp_a = (nval * 4) % 84;
        total++;
        if (fetch_pc !== 32'(exp_a) || fetch_instr !== word_at(32'(exp_a))) begin
          bad++;
          $display("FAIL stream_out[%0d]: pc=%h in=%h want %h",
                   nval, fetch_pc, fetch_instr, 32'(exp_a));
        end
        nval++;
      end
    end
    total++;
    if (nreq != 30 || nval != 29) begin
      bad++;
      $display("FAIL stream_rate: reqs=%0d outs=%0d want 30/29", nreq, nval);
    end
  endtask

  task automatic test_hold();
    m_lat = 1;
    fetch_ready = 1'b0;
    do_reset();
    repeat (2) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (imem_req !== 1'b0 || fetch_valid !== 1'b1 ||
          fetch_instr !== word_at(32'h0)) begin
        bad++;
        $display("FAIL hold[%0d]: req=%b v=%b in=%h want 0/1/%h",
                 c, imem_req, fetch_valid, fetch_instr, word_at(32'h0));
      end
    end
    fetch_ready = 1'b1;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || fetch_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_release: req=%b addr=%h v=%b want 1/4/0",
               imem_req, imem_addr, fetch_valid);
    end
  endtask

  task automatic test_redirect_wait();
    m_lat = 3;
    fetch_ready = 1'b1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    @(negedge clk);
    redirect_valid = 1'b0;
    m_lat = 1;
    for (int c = 0; c < 2; c++) begin
      total++;
      if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin
        bad++;
        $display("FAIL drop[%0d]: req=%b v=%b want 0/0", c, imem_req, fetch_valid);
      end
      @(negedge clk);
    end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20 || fetch_valid !== 1'b0) begin
      bad++;
      $display("FAIL drop_target: req=%b addr=%h v=%b want 1/20/0",
               imem_req, imem_addr, fetch_valid);
    end
    repeat (2) @(negedge clk);
    total++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 32'h20 ||
        fetch_instr !== word_at(32'h20)) begin
      bad++;
      $display("FAIL drop_out: v=%b pc=%h in=%h want 1/20/%h",
               fetch_valid, fetch_pc, fetch_instr, word_at(32'h20));
    end
  endtask

  task automatic test_fault();
    logic [31:0] tgt [2];
    tgt[0] = 32'h22;
    tgt[1] = 32'h60;
    m_lat = 1;
    fetch_ready = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      redirect_valid = 1'b1;
      redirect_pc    = tgt[k];
      @(negedge clk);
      redirect_valid = 1'b0;
      total++;
      if (fetch_fault !== 1'b1 || imem_req !== 1'b1 ||
          imem_addr !== 32'h0 || fetch_valid !== 1'b0) begin
        bad++;
        $display("FAIL fault_hit[%h]: f=%b req=%b addr=%h v=%b want 1/1/0/0",
                 tgt[k], fetch_fault, imem_req, imem_addr, fetch_valid);
      end
      @(negedge clk);
      total++;
      if (fetch_fault !== 1'b0 || fetch_valid !== 1'b0) begin
        bad++;
        $display("FAIL fault_pulse[%h]: f=%b v=%b want 0/0",
                 tgt[k], fetch_fault, fetch_valid);
      end
      @(negedge clk);
      total++;
      if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0 ||
          fetch_instr !== word_at(32'h0)) begin
        bad++;
        $display("FAIL fault_out[%h]: v=%b pc=%h in=%h want 1/0/%h",
                 tgt[k], fetch_valid, fetch_pc, fetch_instr, word_at(32'h0));
      end
    end
  endtask

  task automatic test_xfer_redirect();
    int xfers;
    m_lat = 1;
    fetch_ready = 1'b1;
    do_reset();
    xfers = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
      end else begin
        redirect_valid = 1'b0;
      end
      if (fetch_valid === 1'b1 && fetch_ready === 1'b1) xfers++;
      if (c == 3) begin
        total++;
        if (fetch_valid !== 1'b0 || imem_req !== 1'b1 ||
            imem_addr !== 32'h40 || fetch_fault !== 1'b0) begin
          bad++;
          $display("FAIL xr_next: v=%b req=%b addr=%h f=%b want 0/1/40/0",
                   fetch_valid, imem_req, imem_addr, fetch_fault);
        end
      end
    end
    total++;
    if (xfers != 1) begin
      bad++;
      $display("FAIL xr_count: got %0d want 1", xfers);
    end
    @(negedge clk);
    total++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 32'h40) begin
      bad++;
      $display("FAIL xr_out: v=%b pc=%h want 1/40", fetch_valid, fetch_pc);
    end
  endtask

  task automatic test_reset_mid();
    m_lat = 2;
    fetch_ready = 1'b1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_lat = 1;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || fetch_valid !== 1'b0 ||
        fetch_pc !== 32'h0 || fetch_fault !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: req=%b addr=%h v=%b pc=%h f=%b want 0",
               imem_req, imem_addr, fetch_valid, fetch_pc, fetch_fault);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_first: req=%b addr=%h v=%b want 1/0/0",
               imem_req, imem_addr, fetch_valid);
    end
    repeat (2) @(negedge clk);
    total++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0 ||
        fetch_instr !== word_at(32'h0)) begin
      bad++;
      $display("FAIL mid_out: v=%b pc=%h in=%h want 1/0/%h",
               fetch_valid, fetch_pc, fetch_instr, word_at(32'h0));
    end
  endtask

  initial begin
    clk            = 1'b0;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    fetch_ready    = 1'b1;
    m_lat          = 1;
    m_cnt          = 0;
    m_pend         = 1'b0;
    m_addr         = '0;
    total          = 0;
    bad            = 0;
    test_reset();
    test_stream();
    test_hold();
    test_redirect_wait();
    test_fault();
    test_xfer_redirect();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
